// File: rtl/mat_pkg.sv
// Shared definitions for the matrix result path: default geometry, FSM
// states and the element bit-position helper used by RTL and benches.
package mat_pkg;

  localparam int MAT_W     = 16;
  localparam int MAT_N     = 3;
  localparam int MAT_IDX_W = (MAT_N > 1) ? $clog2(MAT_N) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Element (r,c) sits at this LSB in the flattened bus; (0,0) is at the MSBs.
  function automatic int elem_lsb(input int r, input int c);
    return MAT_W * (MAT_N * MAT_N - 1 - (r * MAT_N + c));
  endfunction

endpackage

// File: rtl/mat_elem_sel.sv
// Combinational N*N:1 element selector: picks element (row,col) out of a
// flattened matrix whose element (0,0) occupies the most significant bits.
module mat_elem_sel
  import mat_pkg::*;
#(
  parameter int W = MAT_W,
  parameter int N = MAT_N,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [W*N*N-1:0] mat,
  input  logic [IDX_W-1:0] row,
  input  logic [IDX_W-1:0] col,
  output logic [W-1:0]     elem
);

  logic [W-1:0] elems [N*N];

  for (genvar gi = 0; gi < N * N; gi++) begin : g_elem
    assign elems[gi] = mat[W*(N*N-1-gi) +: W];
  end

  // Out-of-range indices select zero rather than aliasing another element.
  always_comb begin
    elem = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (row == IDX_W'(r) && col == IDX_W'(c)) begin
          elem = elems[r*N+c];
        end
      end
    end
  end

endmodule

// File: rtl/mat_result_streamer.sv
// Captures one flattened N*N result matrix and streams it out one element per
// valid/ready beat in row-major or column-major order, flagging overruns.
module mat_result_streamer
  import mat_pkg::*;
#(
  parameter int W = MAT_W,
  parameter int N = MAT_N,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_mode,
  input  logic             i_C_valid,
  input  logic [W*N*N-1:0] i_C,
  output logic             o_C_ready,
  output logic [W-1:0]     o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [IDX_W-1:0] o_row,
  output logic [IDX_W-1:0] o_col,
  output logic             o_last,
  output logic             o_busy,
  output logic             o_overrun
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   row_reg, row_next;
  logic [IDX_W-1:0]   col_reg, col_next;
  logic               mode_reg;
  logic [W*N*N-1:0]   shadow_reg;
  logic [W-1:0]       data_reg;
  logic [W-1:0]       sel_elem;
  logic               last_reg;
  logic               last_next;
  logic               overrun_reg;
  logic               capture;
  logic               handshake;

  mat_elem_sel #(
    .W (W),
    .N (N)
  ) u_elem_sel (
    .mat  (shadow_reg),
    .row  (row_next),
    .col  (col_next),
    .elem (sel_elem)
  );

  // o_C_ready is a function of state and i_en only (gated low while in reset).
  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    col_next   = col_reg;
    o_C_ready  = 1'b0;
    o_valid    = 1'b0;
    o_busy     = 1'b0;
    capture    = 1'b0;
    handshake  = 1'b0;

    case (state_reg)
      IDLE: begin
        o_C_ready = i_en && i_rst;
        capture   = i_C_valid && o_C_ready;
        if (capture) begin
          state_next = SEND;
          row_next   = '0;
          col_next   = '0;
        end
      end
      SEND: begin
        o_valid   = 1'b1;
        o_busy    = 1'b1;
        handshake = i_ready;
        if (handshake) begin
          if (last_reg) begin
            state_next = IDLE;
            row_next   = '0;
            col_next   = '0;
          end else if (mode_reg) begin
            if (col_reg == LAST_IDX) begin
              col_next = '0;
              row_next = row_reg + IDX_W'(1);
            end else begin
              col_next = col_reg + IDX_W'(1);
            end
          end else begin
            if (row_reg == LAST_IDX) begin
              row_next = '0;
              col_next = col_reg + IDX_W'(1);
            end else begin
              row_next = row_reg + IDX_W'(1);
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign last_next = (row_next == LAST_IDX) && (col_next == LAST_IDX);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_reg   <= IDLE;
      row_reg     <= '0;
      col_reg     <= '0;
      mode_reg    <= 1'b0;
      shadow_reg  <= '0;
      data_reg    <= '0;
      last_reg    <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      row_reg   <= row_next;
      col_reg   <= col_next;
      // Element (0,0) comes straight off the input bus so it is on o_data
      // the cycle after capture, without waiting for the shadow copy.
      if (capture) begin
        shadow_reg <= i_C;
        mode_reg   <= i_mode;
        data_reg   <= i_C[W*N*N-1 -: W];
        last_reg   <= (N == 1);
      end else if (handshake) begin
        if (last_reg) begin
          last_reg <= 1'b0;
        end else begin
          data_reg <= sel_elem;
          last_reg <= last_next;
        end
      end
      if (i_C_valid && !o_C_ready) begin
        overrun_reg <= 1'b1;
      end
    end
  end

  assign o_data    = data_reg;
  assign o_row     = row_reg;
  assign o_col     = col_reg;
  assign o_last    = last_reg;
  assign o_overrun = overrun_reg;

endmodule

// File: tb/tb_mat_result_streamer.sv
// Scoreboard bench for mat_result_streamer: expected beats are queued at
// capture and compared as handshakes are observed on the falling edge.
module tb_mat_result_streamer;
  import mat_pkg::*;

  localparam int W  = MAT_W;
  localparam int N  = MAT_N;
  localparam int IW = MAT_IDX_W;
  localparam int MW = W * N * N;

  typedef struct {
    logic [W-1:0] d;
    int           r;
    int           c;
    bit           last;
    int           cyc;
  } beat_t;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          i_en = 1'b1;
  logic          i_mode = 1'b1;
  logic          i_C_valid = 1'b0;
  logic [MW-1:0] i_C = '0;
  logic          o_C_ready;
  logic [W-1:0]  o_data;
  logic          o_valid;
  logic          i_ready;
  logic [IW-1:0] o_row;
  logic [IW-1:0] o_col;
  logic          o_last;
  logic          o_busy;
  logic          o_overrun;

  mat_result_streamer #(.W(W), .N(N)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_en      (i_en),
    .i_mode    (i_mode),
    .i_C_valid (i_C_valid),
    .i_C       (i_C),
    .o_C_ready (o_C_ready),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_row     (o_row),
    .o_col     (o_col),
    .o_last    (o_last),
    .o_busy    (o_busy),
    .o_overrun (o_overrun)
  );

  initial forever #5 i_clk = ~i_clk;

  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    hs_cnt = 0;
  int    frame_hs0 = 0;
  bit    bp_en = 1'b0;
  bit    stall_prev = 1'b0;
  bit    cr_pending = 1'b0;
  beat_t sb_q[$];
  logic [W-1:0]  hold_d;
  logic [IW-1:0] hold_r, hold_c;
  logic          hold_l;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(posedge i_clk) cyc++;

  // Backpressure pattern 1,0,0,1 repeating when enabled; otherwise always ready.
  initial begin
    int k = 0;
    i_ready = 1'b1;
    forever begin
      @(posedge i_clk);
      #1;
      if (bp_en) begin
        i_ready = (k % 4 == 0) || (k % 4 == 3);
        k++;
      end else begin
        i_ready = 1'b1;
        k = 0;
      end
    end
  end

  // Monitor: one line per accepted beat, compared against the scoreboard.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      stall_prev = 1'b0;
      cr_pending = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 32'(o_valid), 32'd1);
        check("stall_data", 32'(o_data), 32'(hold_d));
        check("stall_rowcol", 32'({o_row, o_col, o_last}), 32'({hold_r, hold_c, hold_l}));
      end
      if (cr_pending) begin
        check("c_ready_after_last", 32'(o_C_ready), 32'(i_en));
        cr_pending = 1'b0;
      end
      if (o_valid && i_ready) begin
        if (sb_q.size() == 0) begin
          check("extra_beat", 32'd1, 32'd0);
        end else begin
          beat_t e;
          e = sb_q.pop_front();
          $display("beat data=0x%04h row=%0d col=%0d last=%0b cyc=%0d", o_data, o_row, o_col, o_last, cyc);
          check("beat_data", 32'(o_data), 32'(e.d));
          check("beat_row", 32'(o_row), 32'(e.r));
          check("beat_col", 32'(o_col), 32'(e.c));
          check("beat_last", 32'(o_last), 32'(e.last));
          check("beat_busy", 32'(o_busy), 32'd1);
          if (e.cyc >= 0) check("beat_cycle", 32'(cyc), 32'(e.cyc));
          if (e.last) cr_pending = 1'b1;
        end
        hs_cnt++;
      end
      stall_prev = o_valid && !i_ready;
      hold_d = o_data;
      hold_r = o_row;
      hold_c = o_col;
      hold_l = o_last;
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [MW-1:0] make_seq(input int base);
    logic [MW-1:0] m = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        m[elem_lsb(r, c) +: W] = W'(base + r * N + c);
    return m;
  endfunction

  task automatic start_frame(input logic [MW-1:0] m, input bit mode, input bit full);
    int guard = 0;
    while (!o_C_ready && guard < 100) begin
      tick();
      guard++;
    end
    if (!o_C_ready) check("c_ready_timeout", 32'd0, 32'd1);
    i_C = m;
    i_mode = mode;
    i_C_valid = 1'b1;
    frame_hs0 = hs_cnt;
    for (int k = 0; k < N * N; k++) begin
      beat_t e;
      e.r = mode ? k / N : k % N;
      e.c = mode ? k % N : k / N;
      e.d = m[elem_lsb(e.r, e.c) +: W];
      e.last = (k == N * N - 1);
      e.cyc = full ? cyc + 1 + k : -1;
      sb_q.push_back(e);
    end
    tick();
    i_C_valid = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    int guard = 0;
    while ((hs_cnt - frame_hs0) < n && guard < 200) begin
      tick();
      guard++;
    end
    check("wait_beats_timeout", 32'(hs_cnt - frame_hs0 >= n), 32'd1);
  endtask

  task automatic wait_done();
    int guard = 0;
    while (sb_q.size() != 0 && guard < 300) begin
      tick();
      guard++;
    end
    check("frame_drained", 32'(sb_q.size()), 32'd0);
    tick();
    tick();
    check("idle_valid", 32'(o_valid), 32'd0);
  endtask

  task automatic pulse_c_valid(input logic [MW-1:0] m);
    i_C = m;
    i_C_valid = 1'b1;
    tick();
    i_C_valid = 1'b0;
  endtask

  logic [MW-1:0] mat_a;
  logic [MW-1:0] mat_x;

  initial begin
    mat_a = make_seq(1);
    mat_x = '0;
    for (int k = 0; k < N * N; k++) mat_x[k*W +: W] = 16'h3c00;

    // Reset state
    #3;
    check("rst_c_ready", 32'(o_C_ready), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_overrun", 32'(o_overrun), 32'd0);
    check("rst_data", 32'(o_data), 32'd0);
    check("rst_last", 32'(o_last), 32'd0);
    tick();
    tick();
    i_rst = 1'b1;
    tick();
    check("idle_c_ready", 32'(o_C_ready), 32'd1);

    // Row-major and column-major at full rate
    start_frame(mat_a, 1'b1, 1'b1);
    wait_done();
    check("rm_handshakes", 32'(hs_cnt - frame_hs0), 32'(N * N));
    start_frame(mat_a, 1'b0, 1'b1);
    wait_done();

    // Backpressure
    bp_en = 1'b1;
    start_frame(make_seq(16'h0100), 1'b1, 1'b0);
    wait_done();
    check("bp_handshakes", 32'(hs_cnt - frame_hs0), 32'(N * N));
    bp_en = 1'b0;
    tick();

    // Overrun at beat 4
    start_frame(mat_a, 1'b1, 1'b1);
    wait_beats(3);
    check("ovr_before", 32'(o_overrun), 32'd0);
    pulse_c_valid(mat_x);
    check("ovr_rise", 32'(o_overrun), 32'd1);
    wait_done();
    check("ovr_sticky", 32'(o_overrun), 32'd1);

    // Enable gating
    i_rst = 1'b0;
    tick();
    i_rst = 1'b1;
    tick();
    i_en = 1'b0;
    tick();
    check("en0_c_ready", 32'(o_C_ready), 32'd0);
    pulse_c_valid(mat_a);
    check("en0_overrun", 32'(o_overrun), 32'd1);
    tick();
    check("en0_no_capture", 32'(o_valid), 32'd0);
    i_en = 1'b1;
    tick();
    check("en1_no_capture", 32'(o_valid), 32'd0);

    // i_en dropped and i_mode flipped mid-frame
    start_frame(make_seq(16'h0200), 1'b0, 1'b1);
    wait_beats(1);
    i_en = 1'b0;
    i_mode = 1'b1;
    wait_done();
    check("en_drop_handshakes", 32'(hs_cnt - frame_hs0), 32'(N * N));
    i_en = 1'b1;
    tick();

    // Reset mid-frame at beat 5
    start_frame(mat_a, 1'b1, 1'b1);
    wait_beats(4);
    #2;
    i_rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(o_valid), 32'd0);
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    check("mid_rst_overrun", 32'(o_overrun), 32'd0);
    check("mid_rst_last", 32'(o_last), 32'd0);
    sb_q.delete();
    tick();
    tick();
    i_rst = 1'b1;
    tick();
    start_frame(make_seq(16'h0300), 1'b1, 1'b1);
    wait_done();
    check("post_rst_overrun", 32'(o_overrun), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "global timeout");
  end

endmodule
